// File: rtl/palette_memory_dbuf_pkg.sv
// Shared types and default geometry for the double-buffered palette RAM.
// Imported by the write-bus interface, the bank sub-module and the top level.
package palette_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWAP_PEND,
    COPY
  } palette_state_t;

  localparam int unsigned PAL_ENTRY_W = 24;
  localparam int unsigned PAL_BUS_W   = 8;
  localparam int unsigned PAL_BEATS   = 3;
  localparam int unsigned PAL_DEPTH   = 256;

  // Width of the beat field inside a write address; at least one bit.
  function automatic int unsigned pal_beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/palette_memory_dbuf_if.sv
// Multi-beat CPU write bus into the palette shadow bank.
// The CPU drives the master modport; the palette RAM uses the slave modport.
interface palette_memory_dbuf_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BUS_W  = 8
) ();

  logic              write_valid;
  logic              write_ready;
  logic [ADDR_W-1:0] write_addr;
  logic [BUS_W-1:0]  write_data;

  modport master (
    output write_valid,
    output write_addr,
    output write_data,
    input  write_ready
  );

  modport slave (
    input  write_valid,
    input  write_addr,
    input  write_data,
    output write_ready
  );

endinterface

// File: rtl/palette_memory_dbuf_bank.sv
// One palette bank: a single synchronous write port and NUM_RP combinational
// read ports. Out-of-range indices drop writes and read back as zero.
module palette_bank #(
  parameter int unsigned ENTRY_W = 24,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned NUM_RP  = 3,
  parameter int unsigned IDX_W   = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IDX_W-1:0]          waddr,
  input  logic [ENTRY_W-1:0]        wdata,
  input  logic [NUM_RP*IDX_W-1:0]   raddr,
  output logic [NUM_RP*ENTRY_W-1:0] rdata
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned p = 0; p < NUM_RP; p++) begin
      if ({1'b0, raddr[p*IDX_W +: IDX_W]} < DEPTH_L) begin
        rdata[p*ENTRY_W +: ENTRY_W] = mem_q[raddr[p*IDX_W +: IDX_W]];
      end
    end
  end

endmodule

// File: rtl/palette_memory_dbuf.sv
// Double-buffered palette RAM: CPU beats assemble entries into the shadow bank,
// a swap flips banks at frame_start, then a copy engine refreshes the new shadow.
module palette_memory_dbuf
  import palette_pkg::*;
#(
  parameter int unsigned ENTRY_W  = PAL_ENTRY_W,
  parameter int unsigned BUS_W    = PAL_BUS_W,
  parameter int unsigned BEATS    = PAL_BEATS,
  parameter int unsigned DEPTH    = PAL_DEPTH,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned BEAT_W   = pal_beat_w(BEATS)
) (
  input  logic                        clk,
  input  logic                        reset,
  palette_memory_dbuf_if.slave        wr,
  input  logic                        swap_req,
  input  logic                        frame_start,
  output logic                        busy,
  output logic                        swap_done,
  input  logic [NUM_READ*IDX_W-1:0]   read_addr,
  output logic [NUM_READ*ENTRY_W-1:0] read_data,
  output logic                        active_bank
);

  localparam int unsigned CAT_W = BEATS * BUS_W;
  localparam int unsigned RP    = NUM_READ + 1;

  palette_state_t              state_q, state_d;
  logic                        active_q, active_d;
  logic [IDX_W-1:0]            copy_idx_q, copy_idx_d;
  logic                        swap_done_q, swap_done_d;
  logic [BUS_W-1:0]            slot_q [BEATS];
  logic [BUS_W-1:0]            slot_d [BEATS];
  logic [NUM_READ*ENTRY_W-1:0] rd_q, rd_d;

  logic                        wr_fire;
  logic                        commit;
  logic                        copying;
  logic [BEAT_W-1:0]           wr_beat;
  logic [IDX_W-1:0]            wr_idx;
  logic [CAT_W-1:0]            cat;

  logic [RP*IDX_W-1:0]         bank_raddr;
  logic [RP*ENTRY_W-1:0]       bank_rdata [2];
  logic [1:0]                  bank_we;
  logic [IDX_W-1:0]            bank_waddr;
  logic [ENTRY_W-1:0]          bank_wdata;
  logic [ENTRY_W-1:0]          act_copy;

  assign wr.write_ready = (state_q == IDLE);
  assign wr_fire        = wr.write_valid && wr.write_ready;
  assign wr_beat        = wr.write_addr[BEAT_W-1:0];
  assign wr_idx         = wr.write_addr[BEAT_W +: IDX_W];
  assign commit         = wr_fire && (wr_beat == BEAT_W'(BEATS - 1));
  assign copying        = (state_q == COPY);

  // Slot 0 lands in the most significant position; the final beat is the LSBs.
  always_comb begin
    cat = '0;
    for (int unsigned i = 0; i + 1 < BEATS; i++) begin
      cat[(BEATS - 1 - i)*BUS_W +: BUS_W] = slot_q[i];
    end
    cat[BUS_W-1:0] = wr.write_data;
  end

  // The copy engine owns the extra read port; writes only ever hit the shadow.
  assign bank_raddr = {copy_idx_q, read_addr};
  assign act_copy   = bank_rdata[active_q][NUM_READ*ENTRY_W +: ENTRY_W];
  assign bank_waddr = copying ? copy_idx_q : wr_idx;
  assign bank_wdata = copying ? act_copy : cat[ENTRY_W-1:0];
  assign bank_we[0] = active_q && (commit || copying);
  assign bank_we[1] = !active_q && (commit || copying);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    palette_bank #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH),
      .NUM_RP  (RP),
      .IDX_W   (IDX_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (bank_raddr),
      .rdata (bank_rdata[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    copy_idx_d  = copy_idx_q;
    swap_done_d = 1'b0;
    slot_d      = slot_q;
    rd_d        = bank_rdata[active_q][NUM_READ*ENTRY_W-1:0];

    if (wr_fire) begin
      for (int unsigned i = 0; i + 1 < BEATS; i++) begin
        if (wr_beat == BEAT_W'(i)) begin
          slot_d[i] = wr.write_data;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (swap_req) begin
          state_d = SWAP_PEND;
        end
      end
      SWAP_PEND: begin
        if (frame_start) begin
          active_d   = !active_q;
          copy_idx_d = '0;
          state_d    = COPY;
        end
      end
      COPY: begin
        copy_idx_d = copy_idx_q + 1'b1;
        if (copy_idx_q == IDX_W'(DEPTH - 1)) begin
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      copy_idx_q  <= '0;
      swap_done_q <= 1'b0;
      rd_q        <= '0;
      for (int unsigned i = 0; i < BEATS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      copy_idx_q  <= copy_idx_d;
      swap_done_q <= swap_done_d;
      rd_q        <= rd_d;
      slot_q      <= slot_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign swap_done   = swap_done_q;
  assign active_bank = active_q;
  assign read_data   = rd_q;

endmodule

// File: tb/tb_palette_memory_dbuf.sv
// Scoreboard bench for palette_memory_dbuf: stimulus queues expected outputs
// tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_palette_memory_dbuf;

  localparam int ENTRY_W  = 24;
  localparam int BUS_W    = 8;
  localparam int BEATS    = 3;
  localparam int DEPTH    = 256;
  localparam int NUM_READ = 2;
  localparam int IDX_W    = 8;
  localparam int BEAT_W   = 2;
  localparam int ADDR_W   = IDX_W + BEAT_W;

  localparam int SEL_RD0    = 0;
  localparam int SEL_RD1    = 1;
  localparam int SEL_ACTIVE = 2;
  localparam int SEL_BUSY   = 3;
  localparam int SEL_READY  = 4;
  localparam int SEL_DONE   = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic swap_req = 1'b0;
  logic frame_start = 1'b0;
  logic busy, swap_done, active_bank;
  logic [NUM_READ*IDX_W-1:0]   read_addr = '0;
  logic [NUM_READ*ENTRY_W-1:0] read_data;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  palette_memory_dbuf_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) pif ();

  palette_memory_dbuf #(
    .ENTRY_W  (ENTRY_W),
    .BUS_W    (BUS_W),
    .BEATS    (BEATS),
    .DEPTH    (DEPTH),
    .NUM_READ (NUM_READ)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (pif),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .busy        (busy),
    .swap_done   (swap_done),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .active_bank (active_bank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_RD0:    return 32'(read_data[ENTRY_W-1:0]);
      SEL_RD1:    return 32'(read_data[2*ENTRY_W-1:ENTRY_W]);
      SEL_ACTIVE: return 32'(active_bank);
      SEL_BUSY:   return 32'(busy);
      SEL_READY:  return 32'(pif.write_ready);
      SEL_DONE:   return 32'(swap_done);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_at(input int off, input int sel, input logic [31:0] e,
                                    input string n);
    exp_t x;
    x.due  = cyc + off;
    x.sel  = sel;
    x.exp  = e;
    x.name = n;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, pick(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input int idx, input int beat);
    return ADDR_W'((idx << BEAT_W) | beat);
  endfunction

  task automatic set_rd(input int a0, input int a1);
    read_addr = {IDX_W'(a1), IDX_W'(a0)};
  endtask

  task automatic wr_beat(input int idx, input int beat, input logic [7:0] d);
    expect_at(0, SEL_READY, 32'd1, "write_ready on offer");
    pif.write_valid = 1'b1;
    pif.write_addr  = mk_addr(idx, beat);
    pif.write_data  = d;
    tick();
    pif.write_valid = 1'b0;
  endtask

  task automatic do_swap(input bit fs_same, input bit hold_wr, input logic exp_active,
                         input bit chk_rd, input logic [31:0] pre_v, input logic [31:0] post_v);
    int  cnt = 0;
    int  rdy = 0;
    bit  seen = 1'b0;
    swap_req    = 1'b1;
    frame_start = fs_same;
    tick();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    expect_at(0, SEL_BUSY, 32'd1, "busy in SWAP_PEND");
    expect_at(0, SEL_READY, 32'd0, "write_ready in SWAP_PEND");
    if (fs_same) expect_at(0, SEL_ACTIVE, 32'(!exp_active), "no toggle on same-cycle frame_start");
    if (hold_wr) begin
      pif.write_valid = 1'b1;
      pif.write_addr  = mk_addr(5, 2);
      pif.write_data  = 8'hEE;
    end
    tick();
    tick();
    expect_at(0, SEL_ACTIVE, 32'(!exp_active), "active_bank held while pending");
    frame_start = 1'b1;
    if (chk_rd) begin
      set_rd(5, 7);
      expect_at(1, SEL_RD0, pre_v, "read on toggle edge uses old bank");
      expect_at(2, SEL_RD0, post_v, "read after toggle uses new bank");
    end
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (swap_done) begin
        seen = 1'b1;
      end else begin
        if (busy) cnt++;
        if (pif.write_ready) rdy++;
        tick();
      end
    end
    pif.write_valid = 1'b0;
    check("swap_done within bound", 32'(seen), 32'd1);
    check("busy cycles after frame_start", 32'(cnt), 32'(DEPTH));
    check("write_ready cycles during copy", 32'(rdy), 32'd0);
    expect_at(0, SEL_ACTIVE, 32'(exp_active), "active_bank after swap");
    expect_at(0, SEL_READY, 32'd1, "write_ready at swap_done");
    tick();
    expect_at(0, SEL_DONE, 32'd0, "swap_done single pulse");
    expect_at(0, SEL_BUSY, 32'd0, "busy clear after swap");
  endtask

  task automatic expect_reset_state(input string tag);
    expect_at(0, SEL_READY, 32'd1, {tag, " write_ready"});
    expect_at(0, SEL_BUSY, 32'd0, {tag, " busy"});
    expect_at(0, SEL_DONE, 32'd0, {tag, " swap_done"});
    expect_at(0, SEL_ACTIVE, 32'd0, {tag, " active_bank"});
    expect_at(0, SEL_RD0, 32'd0, {tag, " read_data port0"});
    expect_at(0, SEL_RD1, 32'd0, {tag, " read_data port1"});
  endtask

  initial begin
    pif.write_valid = 1'b0;
    pif.write_addr  = '0;
    pif.write_data  = '0;
    tick();
    tick();
    expect_reset_state("reset");
    tick();
    reset = 1'b0;

    // Entry 5 in order, entry 7 out of order, both into shadow bank 1
    wr_beat(5, 0, 8'hAA);
    wr_beat(5, 1, 8'hBB);
    wr_beat(5, 2, 8'hCC);
    wr_beat(7, 1, 8'h0E);
    wr_beat(7, 0, 8'h0F);
    wr_beat(7, 2, 8'h0D);

    do_swap(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    set_rd(5, 7);
    expect_at(1, SEL_RD0, 32'h00AABBCC, "port0 idx5 after swap1");
    expect_at(1, SEL_RD1, 32'h000F0E0D, "port1 idx7 after swap1");
    tick();
    tick();

    wr_beat(5, 0, 8'h12);
    wr_beat(5, 1, 8'h34);
    wr_beat(5, 2, 8'h56);
    set_rd(5, 7);
    expect_at(1, SEL_RD0, 32'h00AABBCC, "shadow write isolated from display");
    tick();
    tick();
    wr_beat(7, 3, 8'h99);

    do_swap(1'b0, 1'b1, 1'b0, 1'b1, 32'h00AABBCC, 32'h00123456);
    set_rd(5, 7);
    expect_at(1, SEL_RD0, 32'h00123456, "port0 idx5 after swap2");
    expect_at(1, SEL_RD1, 32'h000F0E0D, "port1 idx7 unchanged by beat 3");
    tick();
    tick();

    do_swap(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    set_rd(7, 5);
    expect_at(1, SEL_RD0, 32'h000F0E0D, "port0 idx7 after swap3");
    expect_at(1, SEL_RD1, 32'h00123456, "port1 idx5 copied into new shadow");
    tick();
    tick();

    do_swap(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Abort a copy part-way through with reset
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    expect_at(0, SEL_ACTIVE, 32'd1, "active_bank toggled before abort");
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_reset_state("abort");
    repeat (3) begin
      tick();
      expect_at(0, SEL_DONE, 32'd0, "no swap_done after abort");
      expect_at(0, SEL_BUSY, 32'd0, "idle after abort");
    end

    tick();
    tick();
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/palette_memory_dbuf.md
Name: palette_memory_dbuf

Overview:
- Parametrised, double-buffered palette RAM feeding the pixel pipeline.
- CPU writes colour entries as multi-beat bus writes into a shadow bank.
- A swap request makes the shadow bank visible at the next frame_start; an internal copy engine then resynchronises the new shadow from the new active bank.
- NUM_READ independent registered read ports serve the renderers.

Parameters:
ENTRY_W, 24, bits per palette entry
BUS_W, 8, bits per write beat
BEATS, 3, beats per entry; BEATS*BUS_W >= ENTRY_W
DEPTH, 256, entries per bank
NUM_READ, 2, read ports
IDX_W, $clog2(DEPTH), entry index width (derived)
BEAT_W, $clog2(BEATS) min 1, beat field width (derived)

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high
write_valid  in  1  write beat offered
write_ready  out  1  write beat can be accepted
write_addr  in  IDX_W+BEAT_W  {entry index, beat}
write_data  in  BUS_W  beat data
swap_req  in  1  request bank swap (pulse)
frame_start  in  1  frame boundary strobe (pulse)
busy  out  1  swap pending or copy running
swap_done  out  1  one-cycle pulse when copy completes
read_addr  in  NUM_READ*IDX_W  packed read indices, port 0 in LSBs
read_data  out  NUM_READ*ENTRY_W  packed read data, port 0 in LSBs
active_bank  out  1  bank currently displayed

Behaviour:
- Reset values:
  - write_ready=1, busy=0, swap_done=0, active_bank=0, read_data=0.
  - State IDLE; beat buffer zeroed.
  - Bank contents are not reset.
- Write accept: write_valid && write_ready.
- Beat handling:
  - Beat field b < BEATS-1: store write_data in beat buffer slot b.
  - b == BEATS-1: commit ENTRY_W LSBs of {slot0, slot1, ..., slot[BEATS-2], write_data} to shadow[index]. Slot0 is most significant.
  - Commit is visible to reads of the shadow bank on the next cycle.
  - b >= BEATS: accepted, no effect.
- Beat buffer retains slots across entries (no auto-clear); beats may arrive in any order. Only the final beat commits.
- Writes never target the active bank, so display reads are hazard-free.
- FSM:
  - IDLE:
    - write_ready=1.
    - swap_req -> SWAP_PEND. A write accepted in the same cycle still commits.
  - SWAP_PEND:
    - write_ready=0, busy=1.
    - frame_start -> toggle active_bank, copy_idx=0, -> COPY.
    - swap_req ignored.
  - COPY:
    - write_ready=0, busy=1.
    - Each cycle: shadow[copy_idx] <= active[copy_idx]; copy_idx++.
    - After copy_idx == DEPTH-1 is written: swap_done=1 for one cycle, -> IDLE.
    - Duration exactly DEPTH cycles.
    - swap_req and frame_start ignored.
- frame_start and swap_req in the same cycle while IDLE: go to SWAP_PEND only; the swap happens at the next frame_start.
- Reads:
  - read_data[p] <= bank[active_bank][read_addr[p]] at each clk edge: 1-cycle latency, every cycle.
  - On the toggle edge, reads sample the pre-toggle bank.
- Reset mid-COPY or mid-SWAP_PEND: FSM aborts to IDLE, active_bank=0, bank contents undefined (software rewrites).
- Index >= DEPTH (non-power-of-two DEPTH): writes dropped, reads return 0.

Decomposition:
- Shared package palette_pkg:
  - state enum palette_state_t {IDLE, SWAP_PEND, COPY}
  - default constants PAL_ENTRY_W=24, PAL_BUS_W=8, PAL_BEATS=3, PAL_DEPTH=256.
- Sub-module palette_bank, instantiated twice. It has:
  - one synchronous write port;
  - NUM_READ+1 combinational read ports (extra port for the copy engine);
  - distributed/LUT RAM.
- Top level holds the FSM, beat buffer, bank muxing and output registers.

Test Plan:
- Reset, then write beats (idx 5, b0=0x12), (5, b1=0x34), (5, b2=0x56); swap_req; frame_start; wait for swap_done -> read port 0 addr 5 returns 0x123456 one cycle after address applied; active_bank=1.
- Before swap, read addr 5 after the commit -> returns the old active value, not 0x123456. Confirms shadow isolation.
- swap_req asserted; write_valid held -> write_ready=0 until swap_done. A beat presented during SWAP_PEND is not accepted and has no effect after release.
- After swap, frame_start with no request -> count busy cycles: exactly DEPTH=256 cycles high after frame_start. swap_done is a single pulse. Entry 5 in the new shadow = 0x123456 (verified by a second swap).
- reset asserted at copy_idx=100 -> next cycle busy=0, write_ready=1, active_bank=0, read_data=0, no swap_done.
- NUM_READ=2: port0 addr 5, port1 addr 7 in the same cycle -> both correct after 1 cycle. Beat field 3 (>= BEATS) write -> no entry changes.
